// File: rtl/lampboard_shift_driver.sv
// Serializes a captured lamp vector MSB-first into a 74HC595-style chain, then auto-blanks after a hold time.
// Optional macro LAMPBOARD_LAMP_TEST_EN adds a lamp_test input that lights every lamp while held high.
module lampboard_shift_driver #(
    parameter int NUM_LAMPS   = 32,
    parameter int CLK_DIV     = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LAMPS-1:0] lamp_vec,
    input  logic                 lamp_valid,
`ifdef LAMPBOARD_LAMP_TEST_EN
    input  logic                 lamp_test,
`endif
    output logic                 sr_data,
    output logic                 sr_clk,
    output logic                 sr_latch,
    output logic                 sr_oe_n,
    output logic [NUM_LAMPS-1:0] lamps_shown,
    output logic                 busy
);

    localparam int IDX_W  = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(NUM_LAMPS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, HOLD} state_t;

    state_t                state_q, state_d;
    logic [NUM_LAMPS-1:0]  frame_q, frame_d;
    logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
    logic [DIV_W-1:0]      divCnt_q, divCnt_d;
    logic [HOLD_W-1:0]     holdCnt_q, holdCnt_d;
    logic [NUM_LAMPS-1:0]  pend_q, pend_d;
    logic                  pendValid_q, pendValid_d;
    logic [NUM_LAMPS-1:0]  shown_q, shown_d;
    logic                  oeN_q, oeN_d;
    logic                  srData_q, srData_d;
    logic                  srClk_q, srClk_d;
    logic                  srLatch_q, srLatch_d;
    logic                  busy_q, busy_d;

    logic                  reqValid;
    logic [NUM_LAMPS-1:0]  reqVec;
    logic                  holdFreeze;
    logic                  divDone;

`ifdef LAMPBOARD_LAMP_TEST_EN
    logic testSync_q, testPrev_q;
    logic testRise, testFall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            testSync_q <= 1'b0;
            testPrev_q <= 1'b0;
        end else begin
            testSync_q <= lamp_test;
            testPrev_q <= testSync_q;
        end
    end

    // Test edges act as ordinary strobes; a real lamp_valid on the same cycle takes precedence.
    assign testRise   = testSync_q & ~testPrev_q;
    assign testFall   = ~testSync_q & testPrev_q;
    assign reqValid   = lamp_valid | testRise | testFall;
    assign reqVec     = lamp_valid ? lamp_vec : (testRise ? '1 : '0);
    assign holdFreeze = testSync_q;
`else
    assign reqValid   = lamp_valid;
    assign reqVec     = lamp_vec;
    assign holdFreeze = 1'b0;
`endif

    assign divDone = (divCnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            bitIdx_q    <= '0;
            divCnt_q    <= '0;
            holdCnt_q   <= '0;
            pend_q      <= '0;
            pendValid_q <= 1'b0;
            shown_q     <= '0;
            oeN_q       <= 1'b1;
            srData_q    <= 1'b0;
            srClk_q     <= 1'b0;
            srLatch_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            bitIdx_q    <= bitIdx_d;
            divCnt_q    <= divCnt_d;
            holdCnt_q   <= holdCnt_d;
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
            shown_q     <= shown_d;
            oeN_q       <= oeN_d;
            srData_q    <= srData_d;
            srClk_q     <= srClk_d;
            srLatch_q   <= srLatch_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        bitIdx_d    = bitIdx_q;
        divCnt_d    = divCnt_q;
        holdCnt_d   = holdCnt_q;
        pend_d      = pend_q;
        pendValid_d = pendValid_q;
        shown_d     = shown_q;
        oeN_d       = oeN_q;

        // Strobes arriving mid-frame park in the pending slot so the in-flight frame stays intact.
        if (reqValid && (state_q == SHIFT_LO || state_q == SHIFT_HI || state_q == LATCH)) begin
            pend_d      = reqVec;
            pendValid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (reqValid) begin
                    frame_d  = reqVec;
                    bitIdx_d = IDX_MSB;
                    divCnt_d = '0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (divDone) begin
                    divCnt_d = '0;
                    state_d  = SHIFT_HI;
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (divDone) begin
                    divCnt_d = '0;
                    if (bitIdx_q == '0) begin
                        state_d = LATCH;
                    end else begin
                        bitIdx_d = bitIdx_q - IDX_W'(1);
                        state_d  = SHIFT_LO;
                    end
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
            LATCH: begin
                if (divDone) begin
                    divCnt_d = '0;
                    shown_d  = frame_q;
                    oeN_d    = 1'b0;
                    if (reqValid || pendValid_q) begin
                        frame_d     = reqValid ? reqVec : pend_q;
                        pendValid_d = 1'b0;
                        bitIdx_d    = IDX_MSB;
                        state_d     = SHIFT_LO;
                    end else if (frame_q != '0) begin
                        holdCnt_d = HOLD_INIT;
                        state_d   = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (reqValid) begin
                    frame_d   = reqVec;
                    bitIdx_d  = IDX_MSB;
                    divCnt_d  = '0;
                    holdCnt_d = '0;
                    state_d   = SHIFT_LO;
                end else if (!holdFreeze) begin
                    if (holdCnt_q <= HOLD_W'(1)) begin
                        frame_d   = '0;
                        bitIdx_d  = IDX_MSB;
                        divCnt_d  = '0;
                        holdCnt_d = '0;
                        state_d   = SHIFT_LO;
                    end else begin
                        holdCnt_d = holdCnt_q - HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered, keeping the chain glitch-free.
    always_comb begin
        srClk_d   = (state_d == SHIFT_HI);
        srLatch_d = (state_d == LATCH);
        busy_d    = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == LATCH);
        srData_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? frame_d[bitIdx_d] : 1'b0;
    end

    assign sr_data     = srData_q;
    assign sr_clk      = srClk_q;
    assign sr_latch    = srLatch_q;
    assign sr_oe_n     = oeN_q;
    assign lamps_shown = shown_q;
    assign busy        = busy_q;

endmodule
